ps2_keyboard_port: RTL

// - Memory-mapped PS/2 keyboard receiver on the CPU data bus, enabled by Keyboard_Select_H from address_decoder.
// - Deserialises 11-bit PS/2 device-to-host frames and queues scan-code bytes in a FIFO.
// - Drives DataOut, which feeds the DataIn_KEYBOARD leg of the CPU read-data multiplexer.
// - Optionally raises an active-low interrupt while data is pending.

---
 rtl/ps2_keyboard_port.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_keyboard_port.sv
`timescale 1ns/1ps
// ps2_keyboard_port
// Memory-mapped PS/2 keyboard receiver. Deserialises 11-bit device-to-host
// frames (start, 8 data LSB first, odd parity, stop) and queues good scan-code
// bytes in a FIFO that the CPU reads through a small register window.
//
// Ports:
//   Clock           system clock
//   Reset_L         asynchronous active-low reset
//   AS_L            address strobe, active low
//   WE_L            write enable, active low (high = read)
//   Keyboard_Select block select from the address decoder
//   Address[3:0]    byte offset, [3:2] picks DATA/STATUS/CTRL/reserved
//   DataIn[31:0]    CPU write data
//   DataOut[31:0]   register read data, combinational from Address
//   PS2_CLK/PS2_DAT asynchronous PS/2 lines
//   IRQ_Keyboard_L  active-low interrupt
//
// Build option: define PS2_KEYBOARD_IRQ_EN to include the interrupt enable
// bit and the registered interrupt output; otherwise IRQ_Keyboard_L is tied
// high and CTRL[0] reads 0.
module ps2_keyboard_port #(
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic        Clock,
    input  logic        Reset_L,
    input  logic        AS_L,
    input  logic        WE_L,
    input  logic        Keyboard_Select,
    input  logic [3:0]  Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    input  logic        PS2_CLK,
    input  logic        PS2_DAT,
    output logic        IRQ_Keyboard_L
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} rx_state_t;

    logic r_clk_s1, r_clk_s2, r_clk_prev, r_dat_s1, r_dat_s2;
    logic w_fall, w_dat;

    rx_state_t     r_state, w_state_nxt;
    logic [2:0]    r_bit_cnt;
    logic [TW-1:0] r_tmo;
    logic [7:0]    r_shift;
    logic          r_par;
    logic          w_timeout, w_push, w_perr_set, w_ferr_set;

    logic          r_acc_busy;
    logic          w_first, w_pop, w_ctrl_wr, w_clr;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_nonempty, w_full, w_wr_en, w_ovr_set;
    logic          r_ovr, r_ferr, r_perr;
    logic [7:0]    w_head, w_cnt8;
    logic [8:0]    w_cnt9;
    logic          w_irq_en;
    logic          w_unused;

    // Input synchronizers, preset high so reset never looks like a fall.
    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= PS2_CLK;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= PS2_DAT;
            r_dat_s2   <= r_dat_s1;
        end
    end

    assign w_fall = r_clk_prev & ~r_clk_s2;
    assign w_dat  = r_dat_s2;

    // Receiver: a frame stalled for TIMEOUT_CYCLES is silently abandoned.
    assign w_timeout = (r_state != S_IDLE) && !w_fall &&
                       (r_tmo == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_perr_set  = 1'b0;
        w_ferr_set  = 1'b0;
        if (w_timeout) begin
            w_state_nxt = S_IDLE;
        end else if (w_fall) begin
            case (r_state)
                S_IDLE:   if (!w_dat) w_state_nxt = S_DATA;
                S_DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
                S_PARITY: w_state_nxt = S_STOP;
                S_STOP: begin
                    // r_par already folds in the 8 data bits and the parity bit
                    w_state_nxt = S_IDLE;
                    w_perr_set  = ~r_par;
                    w_ferr_set  = ~w_dat;
                    w_push      = r_par & w_dat;
                end
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 3'd0;
            r_tmo     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE || w_fall) r_tmo <= '0;
            else                             r_tmo <= r_tmo + TW'(1);
            if (r_state == S_IDLE)              r_bit_cnt <= 3'd0;
            else if (r_state == S_DATA && w_fall) r_bit_cnt <= r_bit_cnt + 3'd1;
        end
    end

    // Shift/parity accumulators need no reset: both restart at the start bit.
    always_ff @(posedge Clock) begin
        if (w_fall) begin
            if (r_state == S_IDLE)                              r_par <= 1'b0;
            else if (r_state == S_DATA || r_state == S_PARITY)  r_par <= r_par ^ w_dat;
            if (r_state == S_DATA) r_shift <= {w_dat, r_shift[7:1]};
        end
    end

    // Bus side effects fire only on the first cycle of a strobe.
    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L)                       r_acc_busy <= 1'b0;
        else if (AS_L)                      r_acc_busy <= 1'b0;
        else if (Keyboard_Select)           r_acc_busy <= 1'b1;
    end

    assign w_first   = Keyboard_Select & ~AS_L & ~r_acc_busy;
    assign w_nonempty = (r_count != '0);
    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_pop     = w_first & WE_L & (Address[3:2] == 2'd0) & w_nonempty;
    assign w_ctrl_wr = w_first & ~WE_L & (Address[3:2] == 2'd2);
    assign w_clr     = w_ctrl_wr & DataIn[1];
    // A same-cycle pop frees a slot, so a push into a full FIFO still lands.
    assign w_wr_en   = w_push & (~w_full | w_pop);
    assign w_ovr_set = w_push & w_full & ~w_pop;

    always_ff @(posedge Clock) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= r_shift;
    end

    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovr    <= 1'b0;
            r_ferr   <= 1'b0;
            r_perr   <= 1'b0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // Set takes priority over a same-cycle clear.
            r_ovr  <= w_ovr_set  | (r_ovr  & ~w_clr);
            r_ferr <= w_ferr_set | (r_ferr & ~w_clr);
            r_perr <= w_perr_set | (r_perr & ~w_clr);
        end
    end

`ifdef PS2_KEYBOARD_IRQ_EN
    logic r_irq_en, r_irq_l;
    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            r_irq_en <= 1'b0;
            r_irq_l  <= 1'b1;
        end else begin
            if (w_ctrl_wr) r_irq_en <= DataIn[0];
            r_irq_l <= ~(r_irq_en & (w_nonempty | r_ovr));
        end
    end
    assign w_irq_en       = r_irq_en;
    assign IRQ_Keyboard_L = r_irq_l;
`else
    assign w_irq_en       = 1'b0;
    assign IRQ_Keyboard_L = 1'b1;
`endif

    assign w_head   = w_nonempty ? r_mem[r_rd_ptr] : 8'h00;
    // Count is one bit wider than the 8-bit field only when FIFO_DEPTH=256.
    assign w_cnt9   = 9'(r_count);
    assign w_cnt8   = w_cnt9[8] ? 8'hFF : w_cnt9[7:0];
    assign w_unused = ^{Address[1:0], DataIn};

    always_comb begin
        DataOut = 32'h0;
        case (Address[3:2])
            2'd0:    DataOut = {23'h0, w_nonempty, w_head};
            2'd1:    DataOut = {16'h0, w_cnt8, 3'b000, r_ovr, r_ferr, r_perr, w_full, w_nonempty};
            2'd2:    DataOut = {31'h0, w_irq_en};
            default: DataOut = 32'h0;
        endcase
    end

endmodule
